// File: rtl/frame_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_capture_pkg
// Description : Shared types and default geometry for the frame capture
//               block: capture state enumeration and IMG_W/IMG_H/AW defaults.
// Revision    : 1.0  initial release
// ============================================================================
package frame_capture_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int AW_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

endpackage : frame_capture_pkg
`default_nettype wire

// File: rtl/frame_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_capture_ram
// Description : Frame buffer. One write port, one synchronous read port,
//               no reset on storage or read register. A read and a write to
//               the same address on the same edge returns the old contents.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable (read register loads only when high)
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0  initial release
// ============================================================================
module frame_capture_ram #(
    parameter int DEPTH = 65536,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:DEPTH-1];
    logic [7:0] r_rdata;

    // Both accesses in one non-blocking block: the read samples the
    // pre-edge contents, giving read-old-data on an address collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : frame_capture_ram
`default_nettype wire

// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : frame_capture
// Description : Captures one IMG_W x IMG_H frame of 8-bit pixels into an
//               internal buffer after an arm pulse, row-major, one pixel per
//               strobe. Buffer is readable at any time with one-cycle latency.
// Config      : FRAME_CAPTURE_CSUM_EN - when defined, o_csum carries the
//               16-bit modulo sum of captured pixels; otherwise tied to 0.
// Ports       : clk, n_reset (async active-low)
//               i_strb/i_data  - pixel stream
//               arm            - start-capture pulse
//               rd_en/rd_addr/rd_data - buffer read port
//               o_busy/o_done  - capture / done state flags
//               o_col/o_row    - position of the next pixel to be written
//               o_overrun      - sticky: strobe seen while DONE
//               o_csum         - frame checksum
// Revision    : 1.0  initial release
// ============================================================================
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          i_strb,
    input  logic [7:0]    i_data,
    input  logic          arm,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [7:0]    o_col,
    output logic [7:0]    o_row,
    output logic          o_overrun,
    output logic [15:0]   o_csum
);

    localparam logic [7:0]    c_COL_LAST = 8'(IMG_W - 1);
    localparam logic [7:0]    c_ROW_LAST = 8'(IMG_H - 1);
    localparam logic [AW-1:0] c_ADDR_ONE = AW'(1);

    cap_state_t    r_state;
    cap_state_t    w_state_nxt;
    logic          w_wr_en;
    logic          w_restart;
    logic          w_last_px;
    logic [7:0]    r_col;
    logic [7:0]    r_row;
    logic [AW-1:0] r_waddr;
    logic          r_overrun;
    logic          r_rd_valid;
    logic [7:0]    w_ram_q;

    assign w_last_px = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_state_nxt = ST_CAPTURE;
                    w_restart   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // arm is deliberately ignored while a frame is in flight
                if (i_strb) begin
                    w_wr_en = 1'b1;
                    if (w_last_px) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (arm) begin
                    w_state_nxt = ST_CAPTURE;
                    w_restart   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write position. A linear address counter runs alongside col/row so
    // no row*IMG_W multiplier is needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_col   <= 8'd0;
            r_row   <= 8'd0;
            r_waddr <= '0;
        end else if (w_restart) begin
            r_col   <= 8'd0;
            r_row   <= 8'd0;
            r_waddr <= '0;
        end else if (w_wr_en) begin
            if (w_last_px) begin
                r_col   <= 8'd0;
                r_row   <= 8'd0;
                r_waddr <= '0;
            end else if (r_col == c_COL_LAST) begin
                r_col   <= 8'd0;
                r_row   <= r_row + 8'd1;
                r_waddr <= r_waddr + c_ADDR_ONE;
            end else begin
                r_col   <= r_col + 8'd1;
                r_waddr <= r_waddr + c_ADDR_ONE;
            end
        end
    end

    // Overrun: any strobe in DONE not accompanied by arm (arm wins).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_overrun <= 1'b0;
        end else if (w_restart) begin
            r_overrun <= 1'b0;
        end else if ((r_state == ST_DONE) && i_strb) begin
            r_overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Optional checksum
    // ------------------------------------------------------------------
`ifdef FRAME_CAPTURE_CSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_csum <= 16'd0;
        end else if (w_restart) begin
            r_csum <= 16'd0;
        end else if (w_wr_en) begin
            r_csum <= r_csum + {8'h00, i_data};
        end
    end

    assign o_csum = r_csum;
`else
    assign o_csum = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Frame buffer and read path. The RAM read register has no reset, so
    // a reset-cleared valid flag forces rd_data to 0 until the next read.
    // ------------------------------------------------------------------
    frame_capture_ram #(
        .DEPTH (IMG_W * IMG_H),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_waddr),
        .i_wdata (i_data),
        .i_re    (rd_en),
        .i_raddr (rd_addr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rd_valid <= 1'b0;
        end else if (rd_en) begin
            r_rd_valid <= 1'b1;
        end
    end

    assign rd_data   = r_rd_valid ? w_ram_q : 8'h00;
    assign o_busy    = (r_state == ST_CAPTURE);
    assign o_done    = (r_state == ST_DONE);
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_overrun = r_overrun;

endmodule : frame_capture
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_capture
// Description : Self-checking bench for frame_capture on a reduced 16x8
//               frame. A pixel-count model predicts all outputs; directed
//               literal checks pin the model at key points.
// Config      : FRAME_CAPTURE_CSUM_EN selects the expected checksum.
// Revision    : 1.0  initial release
// ============================================================================
module tb_frame_capture;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 7;
    localparam int NPX = W * H;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          i_strb = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic          arm = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          o_busy, o_done, o_overrun;
    logic [7:0]    o_col, o_row;
    logic [15:0]   o_csum;

    int n_cmp = 0;
    int n_bad = 0;

    frame_capture #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_strb    (i_strb),
        .i_data    (i_data),
        .arm       (arm),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_col     (o_col),
        .o_row     (o_row),
        .o_overrun (o_overrun),
        .o_csum    (o_csum)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (pixel-count based) --------------
    bit        m_busy, m_done, m_ovr;
    int        m_n;
    int        m_csum;
    logic [7:0] m_mem   [NPX];
    bit         m_known [NPX];
    logic [7:0] m_rd;
    bit         m_rd_known;

    initial begin
        for (int i = 0; i < NPX; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_busy = 0; m_done = 0; m_ovr = 0; m_n = 0; m_csum = 0;
            m_rd = 8'h00; m_rd_known = 1;
        end else begin
            if (rd_en) begin
                m_rd_known = (int'(rd_addr) < NPX) && m_known[int'(rd_addr)];
                if (m_rd_known) m_rd = m_mem[int'(rd_addr)];
            end
            if (!m_busy) begin
                if (arm) begin
                    m_busy = 1; m_done = 0; m_ovr = 0; m_n = 0; m_csum = 0;
                end else if (m_done && i_strb) begin
                    m_ovr = 1;
                end
            end else if (i_strb) begin
                m_mem[m_n] = i_data;
                m_known[m_n] = 1;
                m_csum = (m_csum + int'(i_data)) % 65536;
                m_n++;
                if (m_n == NPX) begin
                    m_busy = 0; m_done = 1; m_n = 0;
                end
            end
        end
    end

    function automatic logic [15:0] exp_csum(input int s);
`ifdef FRAME_CAPTURE_CSUM_EN
        return 16'(s);
`else
        return 16'(s * 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ---------------
    always @(negedge clk) begin
        chk("busy",    32'(o_busy),    32'(m_busy));
        chk("done",    32'(o_done),    32'(m_done));
        chk("col",     32'(o_col),     32'(m_n % W));
        chk("row",     32'(o_row),     32'(m_n / W));
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
        chk("csum",    32'(o_csum),    32'(exp_csum(m_csum)));
        if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [7:0] d, input int gap);
        i_strb = 1'b1; i_data = d;
        tick();
        i_strb = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset state
        #2;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_col",  32'(o_col),  0);
        chk("rst_csum", 32'(o_csum), 0);
        chk("rst_rd",   32'(rd_data), 0);
        tick(); tick();
        n_reset = 1'b1;
        tick();

        // Strobes before arm are ignored; then full frame with idle gaps
        for (int i = 0; i < 10; i++) px(8'hAA, 1);
        pulse_arm();
        for (int i = 0; i < NPX; i++) px(8'(i), (i == NPX - 1) ? 0 : 16);
        chk("t1_done",   32'(o_done), 1);
        chk("t1_busy",   32'(o_busy), 0);
        chk("t1_col",    32'(o_col),  0);
        chk("t1_csum",   32'(o_csum), 32'(exp_csum(16'h1FC0)));
        chk("t1_ovr",    32'(o_overrun), 0);
        rd(0);
        chk("t1_addr0",  32'(rd_data), 32'h00);
        rd(18);
        chk("t1_addr18", 32'(rd_data), 32'h12);
        tick();
        chk("t1_hold",   32'(rd_data), 32'h12);

        // Strobes in DONE set overrun, do not write
        for (int i = 0; i < 3; i++) px(8'hFF, 1);
        chk("t2_ovr", 32'(o_overrun), 1);
        rd(0);
        chk("t2_addr0", 32'(rd_data), 32'h00);
        pulse_arm();
        chk("t2_ovr_clr", 32'(o_overrun), 0);
        chk("t2_col",  32'(o_col), 0);
        chk("t2_row",  32'(o_row), 0);
        chk("t2_busy", 32'(o_busy), 1);

        // Continuous strobes
        i_strb = 1'b1;
        for (int i = 0; i < NPX; i++) begin
            i_data = 8'(i * 7 + 3);
            if (i == NPX - 1) chk("t3_notyet", 32'(o_done), 0);
            tick();
        end
        i_strb = 1'b0;
        chk("t3_done", 32'(o_done), 1);
        for (int a = 0; a < NPX; a++) rd(a);
        tick();

        // Read/write collision on address 5
        pulse_arm();
        for (int i = 0; i < 5; i++) px(8'(8'h50 + i), 0);
        i_strb = 1'b1; i_data = 8'hC5; rd_en = 1'b1; rd_addr = AW'(5);
        tick();
        i_strb = 1'b0; rd_en = 1'b0;
        chk("t4_old", 32'(rd_data), 32'h26);
        rd(5);
        chk("t4_new", 32'(rd_data), 32'hC5);

        // Reset mid-capture
        for (int i = 6; i < 40; i++) px(8'(i), 1);
        chk("t5_col_pre", 32'(o_col), 8);
        chk("t5_row_pre", 32'(o_row), 2);
        n_reset = 1'b0;
        #1;
        chk("t5_busy", 32'(o_busy), 0);
        chk("t5_col",  32'(o_col),  0);
        chk("t5_row",  32'(o_row),  0);
        tick(); tick();
        n_reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) px(8'h33, 0);
        chk("t5_ign_col",  32'(o_col),  0);
        chk("t5_ign_busy", 32'(o_busy), 0);

        // arm with strobe: not captured; arm in CAPTURE ignored
        arm = 1'b1; i_strb = 1'b1; i_data = 8'h77;
        tick();
        arm = 1'b0; i_strb = 1'b0;
        chk("t6_col0", 32'(o_col), 0);
        px(8'h11, 0);
        chk("t6_col1", 32'(o_col), 1);
        pulse_arm();
        chk("t6_arm_ign", 32'(o_col), 1);
        for (int i = 1; i < NPX; i++) px(8'(i) ^ 8'h5A, (i % 3));
        chk("t6_done", 32'(o_done), 1);
        rd(0);
        chk("t6_addr0", 32'(rd_data), 32'h11);
        rd(1);
        chk("t6_addr1", 32'(rd_data), 32'h5B);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_frame_capture
`default_nettype wire

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 256, rows per frame.
REQ-003 SHALL have parameter AW, default 16, address width (2^AW >= IMG_W*IMG_H).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_strb  input  1  pixel valid strobe, one pixel per high cycle.
REQ-007 SHALL have port i_data  input  8  pixel value, sampled when i_strb=1.
REQ-008 SHALL have port arm  input  1  one-cycle pulse, starts a capture.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_addr  input  AW  read address, row-major (row*IMG_W+col).
REQ-011 SHALL have port rd_data  output  8  read data.
REQ-012 SHALL have port o_busy  output  1  high in CAPTURE.
REQ-013 SHALL have port o_done  output  1  high in DONE.
REQ-014 SHALL have port o_col  output  8  column of next pixel to be written.
REQ-015 SHALL have port o_row  output  8  row of next pixel to be written.
REQ-016 SHALL have port o_overrun  output  1  sticky; a strobe arrived in DONE.
REQ-017 SHALL have port o_csum  output  16  frame checksum.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, DONE.
REQ-019 IDLE: i_strb ignored; arm -> CAPTURE, clears col/row/csum/o_overrun.
REQ-020 CAPTURE: each i_strb writes i_data to mem[row*IMG_W+col], then increments col; on col=IMG_W-1, col wraps to 0 and row increments.
REQ-021 Strobes may be back-to-back (every cycle) or separated by any gap; no pixel lost.
REQ-022 Write of pixel (IMG_W-1, IMG_H-1) -> DONE on the same edge; o_done=1 and o_busy=0 from the following cycle; col/row read 0.
REQ-023 DONE: strobes do not write memory and set o_overrun; arm -> CAPTURE with REQ-019 clears.
REQ-024 arm during CAPTURE is ignored; arm together with i_strb in IDLE/DONE: state change only, that pixel not captured.
REQ-025 Read: rd_en at edge N -> rd_data valid after edge N+1, in any state; rd_data holds when rd_en=0.
REQ-026 Read and write to the same address on the same edge returns the old data.
REQ-027 o_csum = 16-bit modulo sum of all captured pixels, updated on each write edge.

Reset
REQ-028 n_reset low SHALL force IDLE, o_busy=0, o_done=0, o_col=0, o_row=0, o_overrun=0, o_csum=0, rd_data=0, at once without a clock edge.
REQ-029 Reset mid-capture SHALL abandon the frame; memory contents are undefined and are not cleared.

Configuration
REQ-030 Macro FRAME_CAPTURE_CSUM_EN defined: o_csum per REQ-027; undefined: o_csum tied to 0 and no accumulator is built.

Structure
REQ-031 Package frame_capture_pkg SHALL hold the state enumeration and the IMG_W/IMG_H/AW defaults.
REQ-032 Memory SHALL be sub-module frame_capture_ram: one write port, one synchronous read port, no reset.

Verification
REQ-033 Arm, then send 65536 pixels with data=idx[7:0] and 16 idle cycles between strobes -> o_done=1 one cycle after the last strobe; read 0x1234 returns 0x34; o_csum=0x8000 (macro on).
REQ-034 Send 10 strobes before arm, then arm and a full frame -> addr 0 holds the first post-arm pixel; o_overrun=0.
REQ-035 Full frame with i_strb held high continuously -> every address matches; o_done after exactly 65536 strobe cycles.
REQ-036 Assert n_reset after 1000 pixels -> o_busy=0, o_col=0, o_row=0 immediately; later strobes ignored until arm.
REQ-037 After DONE, 3 strobes of 0xFF -> o_overrun=1, addr 0 unchanged; arm clears o_overrun and restarts at col=0/row=0.
REQ-038 Read addr 5 on the same edge as the write of pixel 5 -> old value returned; re-read gives the new value.
